// File: rtl/lexington_pkg.sv
// Shared constants and types for the multi-channel machine timer.
// Register word addresses, control register layout and reset prescale helper.
package lexington_pkg;

  localparam int MTIMER_MAX_CMP       = 8;
  localparam int MTIMER_ADDR_MTIME_LO = 0;
  localparam int MTIMER_ADDR_MTIME_HI = 1;
  localparam int MTIMER_ADDR_CTRL     = 2;
  localparam int MTIMER_ADDR_PRESCALE = 3;
  localparam int MTIMER_ADDR_CMP_BASE = 4;

  localparam longint DEFAULT_CLK_FREQ = 100_000_000;
  localparam longint MTIME_PERIOD_NS  = 100;

  typedef struct packed {
    logic [30:0] reserved;
    logic        en;
  } mtimer_ctrl_t;

  // Clock cycles per mtime tick minus one, for a given core clock in Hz.
  function automatic logic [31:0] calc_prescale(input longint clk_freq);
    return 32'((clk_freq * MTIME_PERIOD_NS) / longint'(1_000_000_000) - longint'(1));
  endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Tick generator for mtime: counts 0..prescale while enabled, pulsing tick on the
// terminal count. Held at zero while disabled or cleared.
module mtimer_prescaler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] prescale,
  input  logic        clear,
  output logic        tick
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    tick = en && (cnt_q == prescale);
    if (clear || !en || tick) cnt_d = '0;
    else                      cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mtimer_multi.sv
// Memory-mapped RISC-V machine timer with NUM_CMP compare channels.
// Define MTIMER_SNAPSHOT_EN to latch mtime[63:32] on a low-word read for coherent 64-bit reads.
module mtimer_multi
  import lexington_pkg::*;
#(
  parameter longint CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int     NUM_CMP  = 1,
  parameter int     ADDR_W   = $clog2(4 + 2*NUM_CMP)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [31:0]        wr_data,
  input  logic [3:0]         wr_strobe,
  output logic [31:0]        rd_data,
  output logic [63:0]        time_rd_data,
  output logic [NUM_CMP-1:0] interrupt
);

  localparam logic [31:0] PRESCALE_RST = calc_prescale(CLK_FREQ);

  logic               en_q, en_d;
  logic [31:0]        prescale_q, prescale_d;
  logic [63:0]        mtime_q, mtime_d;
  logic [63:0]        cmp_q [NUM_CMP];
  logic [63:0]        cmp_d [NUM_CMP];
  logic [NUM_CMP-1:0] irq_q, irq_d;
  logic [31:0]        wdata_m;
  logic [31:0]        hi_rd;
  logic [31:0]        rd_reg;
  logic               presc_clear;
  logic               tick;
  mtimer_ctrl_t       ctrl_rd;

  mtimer_prescaler u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en_q),
    .prescale (prescale_q),
    .clear    (presc_clear),
    .tick     (tick)
  );

  // Strobed-off bytes are written as zero rather than preserved.
  assign wdata_m = wr_data & {{8{wr_strobe[3]}}, {8{wr_strobe[2]}},
                              {8{wr_strobe[1]}}, {8{wr_strobe[0]}}};

  assign presc_clear = wr_en && (addr == ADDR_W'(MTIMER_ADDR_CTRL) ||
                                 addr == ADDR_W'(MTIMER_ADDR_PRESCALE));

  always_comb begin
    en_d       = en_q;
    prescale_d = prescale_q;
    cmp_d      = cmp_q;
    // The unwritten half keeps its post-increment value, so a carry comes from the old low word.
    mtime_d    = mtime_q + 64'(tick);
    if (wr_en) begin
      if (addr == ADDR_W'(MTIMER_ADDR_MTIME_LO)) mtime_d[31:0]  = wdata_m;
      if (addr == ADDR_W'(MTIMER_ADDR_MTIME_HI)) mtime_d[63:32] = wdata_m;
      if (addr == ADDR_W'(MTIMER_ADDR_CTRL))     en_d           = wdata_m[0];
      if (addr == ADDR_W'(MTIMER_ADDR_PRESCALE)) prescale_d     = wdata_m;
      for (int i = 0; i < NUM_CMP; i++) begin
        if (addr == ADDR_W'(MTIMER_ADDR_CMP_BASE + 2*i))     cmp_d[i][31:0]  = wdata_m;
        if (addr == ADDR_W'(MTIMER_ADDR_CMP_BASE + 2*i + 1)) cmp_d[i][63:32] = wdata_m;
      end
    end
    for (int i = 0; i < NUM_CMP; i++) irq_d[i] = (mtime_q >= cmp_q[i]);
  end

`ifdef MTIMER_SNAPSHOT_EN
  logic [31:0] shadow_q, shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    if (rd_en && addr == ADDR_W'(MTIMER_ADDR_MTIME_LO)) shadow_d = mtime_q[63:32];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) shadow_q <= '0;
    else        shadow_q <= shadow_d;
  end

  assign hi_rd = shadow_q;
`else
  assign hi_rd = mtime_q[63:32];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q       <= 1'b1;
      prescale_q <= PRESCALE_RST;
      mtime_q    <= '0;
      irq_q      <= '0;
      for (int i = 0; i < NUM_CMP; i++) cmp_q[i] <= '1;
    end else begin
      en_q       <= en_d;
      prescale_q <= prescale_d;
      mtime_q    <= mtime_d;
      irq_q      <= irq_d;
      for (int i = 0; i < NUM_CMP; i++) cmp_q[i] <= cmp_d[i];
    end
  end

  always_comb begin
    ctrl_rd    = '0;
    ctrl_rd.en = en_q;
    rd_reg     = '0;
    if      (addr == ADDR_W'(MTIMER_ADDR_MTIME_LO)) rd_reg = mtime_q[31:0];
    else if (addr == ADDR_W'(MTIMER_ADDR_MTIME_HI)) rd_reg = hi_rd;
    else if (addr == ADDR_W'(MTIMER_ADDR_CTRL))     rd_reg = ctrl_rd;
    else if (addr == ADDR_W'(MTIMER_ADDR_PRESCALE)) rd_reg = prescale_q;
    for (int i = 0; i < NUM_CMP; i++) begin
      if (addr == ADDR_W'(MTIMER_ADDR_CMP_BASE + 2*i))     rd_reg = cmp_q[i][31:0];
      if (addr == ADDR_W'(MTIMER_ADDR_CMP_BASE + 2*i + 1)) rd_reg = cmp_q[i][63:32];
    end
    rd_data = rd_en ? rd_reg : 32'd0;
  end

  assign time_rd_data = mtime_q;
  assign interrupt    = irq_q;

endmodule

// File: tb/tb_mtimer_multi.sv
// Self-checking bench for mtimer_multi with three compare channels at 100 MHz.
// Expected values are queued when a transaction is driven and compared when sampled.
module tb_mtimer_multi;
  import lexington_pkg::*;

  localparam int NUM_CMP = 3;
  localparam int ADDR_W  = $clog2(4 + 2*NUM_CMP);

  localparam logic [ADDR_W-1:0] A_LO   = 0;
  localparam logic [ADDR_W-1:0] A_HI   = 1;
  localparam logic [ADDR_W-1:0] A_CTRL = 2;
  localparam logic [ADDR_W-1:0] A_PRE  = 3;
  localparam logic [ADDR_W-1:0] A_C0L  = 4;
  localparam logic [ADDR_W-1:0] A_C0H  = 5;
  localparam logic [ADDR_W-1:0] A_C2H  = 9;
  localparam logic [ADDR_W-1:0] A_UNM  = 12;

`ifdef MTIMER_SNAPSHOT_EN
  localparam logic [31:0] SNAP_HI = 32'd3;
`else
  localparam logic [31:0] SNAP_HI = 32'd4;
`endif

  logic               clk;
  logic               rst_n;
  logic               rd_en;
  logic               wr_en;
  logic [ADDR_W-1:0]  addr;
  logic [31:0]        wr_data;
  logic [3:0]         wr_strobe;
  logic [31:0]        rd_data;
  logic [63:0]        time_rd_data;
  logic [NUM_CMP-1:0] interrupt;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  mtimer_multi #(
    .CLK_FREQ (DEFAULT_CLK_FREQ),
    .NUM_CMP  (NUM_CMP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_en        (rd_en),
    .wr_en        (wr_en),
    .addr         (addr),
    .wr_data      (wr_data),
    .wr_strobe    (wr_strobe),
    .rd_data      (rd_data),
    .time_rd_data (time_rd_data),
    .interrupt    (interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_chk(input logic [63:0] got);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, got, e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] strb);
    addr      = a;
    wr_data   = d;
    wr_strobe = strb;
    wr_en     = 1'b1;
    step();
    wr_en     = 1'b0;
    wr_strobe = 4'h0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string tag);
    addr  = a;
    rd_en = 1'b1;
    sb_push(tag, 64'(exp));
    @(negedge clk);
    sb_pop_chk(64'(rd_data));
    step();
    rd_en = 1'b0;
  endtask

  task automatic irq_chk(input logic [NUM_CMP-1:0] exp, input string tag);
    sb_push(tag, 64'(exp));
    @(negedge clk);
    sb_pop_chk(64'(interrupt));
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    addr      = '0;
    wr_data   = '0;
    wr_strobe = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset values and default prescale (tick every 10 cycles)
    rd(A_PRE, 32'd9, "rst_prescale");
    rd(A_CTRL, 32'd1, "rst_ctrl");
    rd(A_C0L, 32'hFFFF_FFFF, "rst_cmp0_lo");
    rd(A_LO, 32'd0, "rst_mtime_c3");
    irq_chk('0, "rst_irq");
    wait_cyc(5);
    rd(A_LO, 32'd1, "mtime_c10");
    wait_cyc(18);
    rd(A_LO, 32'd2, "mtime_c29");
    rd(A_LO, 32'd3, "mtime_c30");
    rd(A_HI, 32'd0, "mtime_hi_c31");
    rd(A_C2H, 32'hFFFF_FFFF, "rst_cmp2_hi");

    // Enable off freezes mtime; re-enable ticks after PRESCALE+1 cycles
    wr(A_CTRL, 32'd0, 4'hF);
    wr(A_LO, 32'd0, 4'hF);
    wr(A_HI, 32'd0, 4'hF);
    rd(A_LO, 32'd0, "freeze_start");
    wait_cyc(50);
    rd(A_LO, 32'd0, "freeze_50");
    wr(A_CTRL, 32'd1, 4'hF);
    wait_cyc(9);
    rd(A_LO, 32'd0, "en_before_tick");
    rd(A_LO, 32'd1, "en_first_tick");

    // Byte-masked writes and CTRL reserved bits
    wr(A_CTRL, 32'hFFFF_FFFE, 4'hF);
    rd(A_CTRL, 32'd0, "ctrl_raz");
    wr(A_LO, 32'hAABB_CCDD, 4'b0011);
    rd(A_LO, 32'h0000_CCDD, "strobe_lo");
    wr(A_HI, 32'h1122_3344, 4'b1100);
    rd(A_HI, 32'h1122_0000, "strobe_hi");

    // Carry into hi and 64-bit wrap with PRESCALE=0
    wr(A_PRE, 32'd0, 4'hF);
    wr(A_LO, 32'hFFFF_FFFF, 4'hF);
    wr(A_HI, 32'd0, 4'hF);
    wr(A_CTRL, 32'd1, 4'hF);
    rd(A_HI, 32'd0, "carry_pre");
    rd(A_HI, 32'd1, "carry_hi");
    rd(A_LO, 32'd1, "carry_lo");
    wr(A_CTRL, 32'd0, 4'hF);
    wr(A_LO, 32'hFFFF_FFFF, 4'hF);
    wr(A_HI, 32'hFFFF_FFFF, 4'hF);
    wr(A_CTRL, 32'd1, 4'hF);
    rd(A_LO, 32'hFFFF_FFFF, "wrap_pre");
    rd(A_HI, 32'd0, "wrap_hi");
    rd(A_LO, 32'd1, "wrap_lo");

    // Writes to mtime halves coinciding with a tick
    wr(A_CTRL, 32'd0, 4'hF);
    wr(A_HI, 32'd5, 4'hF);
    wr(A_LO, 32'hFFFF_FFFF, 4'hF);
    wr(A_CTRL, 32'd1, 4'hF);
    wr(A_LO, 32'h100, 4'hF);
    rd(A_HI, 32'd6, "tick_wr_lo_carry");
    rd(A_LO, 32'h101, "tick_wr_lo_val");
    wr(A_HI, 32'h20, 4'hF);
    rd(A_LO, 32'h103, "tick_wr_hi_lo");
    rd(A_HI, 32'h20, "tick_wr_hi_val");

    // Channel 0 interrupt: rises one cycle after mtime==5, follows level
    wr(A_CTRL, 32'd0, 4'hF);
    wr(A_LO, 32'd0, 4'hF);
    wr(A_HI, 32'd0, 4'hF);
    wr(A_C0H, 32'd0, 4'hF);
    wr(A_C0L, 32'd5, 4'hF);
    irq_chk('0, "irq_idle");
    wr(A_CTRL, 32'd1, 4'hF);
    wait_cyc(5);
    irq_chk(3'b000, "irq0_at_match");
    irq_chk(3'b001, "irq0_rise");
    wr(A_C0H, 32'd1, 4'hF);
    irq_chk(3'b001, "irq0_hold");
    irq_chk(3'b000, "irq0_level");

    // Same-cycle read and write, unmapped address, read enable gating
    addr      = A_PRE;
    wr_data   = 32'd7;
    wr_strobe = 4'hF;
    wr_en     = 1'b1;
    rd_en     = 1'b1;
    sb_push("rw_same_addr", 64'd0);
    @(negedge clk);
    sb_pop_chk(64'(rd_data));
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    rd(A_PRE, 32'd7, "rw_post_write");
    wr(A_UNM, 32'hDEAD_BEEF, 4'hF);
    rd(A_UNM, 32'd0, "unmapped_rd");
    addr = A_PRE;
    @(negedge clk);
    chk("rd_en_low", 64'(rd_data), 64'd0);
    step();

    // Coherent 64-bit read across a carry (shadow only in snapshot builds)
    wr(A_CTRL, 32'd0, 4'hF);
    wr(A_PRE, 32'd0, 4'hF);
    wr(A_HI, 32'd3, 4'hF);
    wr(A_LO, 32'hFFFF_FFFF, 4'hF);
    wr(A_CTRL, 32'd1, 4'hF);
    rd(A_LO, 32'hFFFF_FFFF, "snap_lo");
    rd(A_HI, SNAP_HI, "snap_hi");
    @(negedge clk);
    chk("time_live", time_rd_data, 64'h4_0000_0001);
    step();

    // Reset in the middle of operation
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rd(A_PRE, 32'd9, "rst2_prescale");
    rd(A_LO, 32'd0, "rst2_mtime");
    rd(A_HI, 32'd0, "rst2_hi");
    rd(A_C0H, 32'hFFFF_FFFF, "rst2_cmp0_hi");
    rd(A_CTRL, 32'd1, "rst2_ctrl");
    irq_chk('0, "rst2_irq");

    if (sb_q.size() != 0) chk("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
